i2c_target_responder: RTL

I2C target (slave) engine: the responding end of the bus that the APB I2C master drives. Monitors SCL/SDA, detects START/STOP, matches a 7-bit address, and ACKs write bytes while delivering them to the local side. Serves read bytes from a local source and sends them onto SDA, releasing SDA when the master NACKs. Used as the bus-level counterpart in master verification and as a reusable target core; no clock stretching, no multi-master arbitration, no 10-bit/general-call addressing.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_bus_monitor.sv | 59 +++++
 rtl/i2c_target_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target responder.
//   i2c_target_state_e : protocol FSM states
//   I2C_ADDR_W / I2C_BYTE_W : address and data widths
//   I2C_IDLE_BYTE : byte sent on a read when the local source has nothing
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic [I2C_BYTE_W-1:0] I2C_IDLE_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_target_state_e;
endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: brings raw SCL/SDA into the clk domain and produces
// single-cycle event strobes.
//   clk, reset      : clock, synchronous active-high reset
//   scl_in, sda_in  : raw pin levels (asynchronous)
//   scl_rise/fall   : one-cycle SCL edge strobes
//   start_det       : SDA 1->0 while SCL high
//   stop_det        : SDA 0->1 while SCL high
//   sda_s           : SDA level aligned with the strobes
module i2c_bus_monitor (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;
  logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d;

  always_comb begin
    scl_s1_d = scl_in;
    scl_s2_d = scl_s1_q;
    scl_h_d  = scl_s2_q;
    sda_s1_d = sda_in;
    sda_s2_d = sda_s1_q;
    sda_h_d  = sda_s2_q;
    rise_d   = scl_s2_q & ~scl_h_q;
    fall_d   = ~scl_s2_q & scl_h_q;
    // SCL must be high on both samples so an SDA move during an SCL edge
    // is never mistaken for a bus condition.
    start_d  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    stop_d   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  end

  // Synchronizers preset to 1 so reset looks like an idle bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
      rise_q   <= 1'b0; fall_q   <= 1'b0;
      start_q  <= 1'b0; stop_q   <= 1'b0;
    end else begin
      scl_s1_q <= scl_s1_d; scl_s2_q <= scl_s2_d; scl_h_q <= scl_h_d;
      sda_s1_q <= sda_s1_d; sda_s2_q <= sda_s2_d; sda_h_q <= sda_h_d;
      rise_q   <= rise_d;   fall_q   <= fall_d;
      start_q  <= start_d;  stop_q   <= stop_d;
    end
  end

  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_s     = sda_h_q;
endmodule

// File: rtl/i2c_target_responder.sv
// i2c_target_responder: 7-bit-address I2C target. ACKs and delivers write
// bytes, serves read bytes from a local source, no clock stretching.
//   TARGET_ADDR          : address this target answers
//   clk, reset           : clock, synchronous active-high reset
//   scl_in, sda_in       : raw bus pins
//   sda_oe               : 1 = pull SDA low
//   rx_data, rx_valid    : received write byte + one-cycle strobe
//   tx_data, tx_valid    : next read byte from the local side
//   tx_ready             : pulse, tx_data consumed
//   tx_underrun          : pulse, byte needed but tx_valid low (0xFF sent)
//   addr_match, busy     : addressed / bus-busy status
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  addr_match,
  output logic                  busy
);
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_target_state_e     state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d, shift_in;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d, ld_byte;
  logic sda_oe_q, sda_oe_d, am_q, am_d, busy_q, busy_d;
  logic rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d, tx_unr_q, tx_unr_d;
  // rw_q: R/W bit of the address byte.
  // phase_q: ADDR_ACK/WR_ACK -> ACK already driven; RD_ACK -> master ACK seen.
  logic rw_q, rw_d, phase_q, phase_d, load_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    am_d       = am_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    tx_unr_d   = 1'b0;
    load_en    = 1'b0;
    shift_in   = {shift_q[I2C_BYTE_W-2:0], sda_s};
    ld_byte    = tx_valid ? tx_data : I2C_IDLE_BYTE;

    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      am_d     = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      am_d     = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shift_in[7:1] == TARGET_ADDR) begin
              state_d = ST_ADDR_ACK;
              rw_d    = shift_in[0];
              phase_d = 1'b0;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            am_d     = 1'b1;
            phase_d  = 1'b1;
          end else if (!rw_q) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = ST_WR_DATA;
          end else begin
            load_en = 1'b1;
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = ST_WR_ACK;
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = ST_WR_DATA;
          end
        end
        // Bit 7 goes out at load time; each later fall shifts the next bit
        // out, and the fall ending bit 0 releases SDA for the master's ACK.
        ST_RD_DATA: if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = ST_RD_ACK;
          end else begin
            cnt_d    = cnt_q + 3'd1;
            shift_d  = {shift_q[I2C_BYTE_W-2:0], 1'b1};
            sda_oe_d = ~shift_q[I2C_BYTE_W-2];
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = ST_WAIT_STOP;
            else       phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            load_en = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load_en) begin
      shift_d    = ld_byte;
      sda_oe_d   = ~ld_byte[I2C_BYTE_W-1];
      cnt_d      = 3'd0;
      state_d    = ST_RD_DATA;
      tx_ready_d = tx_valid;
      tx_unr_d   = ~tx_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      am_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_unr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      am_q       <= am_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      tx_unr_q   <= tx_unr_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_unr_q;
  assign addr_match  = am_q;
  assign busy        = busy_q;
endmodule
